// File: rtl/mul_iter.sv
// mul_iter: iterative sign-magnitude multiplier for the MIX arithmetic unit.
// Produces the exact 2*WIDTH-bit product magnitude of two WIDTH-bit
// magnitudes plus the XOR of their signs. STEP multiplier bits are retired
// per clock, so one operation takes WIDTH/STEP cycles behind a
// start/busy/done handshake. A zero product keeps its computed sign
// (MIX negative zero is meaningful and is not normalised).
module mul_iter #(
  parameter int WIDTH = 30,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic                 sign_a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign_b,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_sign,
  output logic                 busy,
  output logic                 done
);

  // Iteration count and a counter just wide enough to hold N-1.
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // A STEP that does not divide WIDTH would leave multiplier bits unused.
  if ((WIDTH % STEP) != 0) begin : g_bad_step
    $error("mul_iter: WIDTH must be a multiple of STEP");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_n_s;

  // Multiplicand pre-aligned to the current multiplier digit position.
  logic [2*WIDTH-1:0]   a_sh_r;
  logic [2*WIDTH-1:0]   a_sh_n_s;
  // Multiplier bits not yet consumed, lowest digit in [STEP-1:0].
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     b_n_s;
  logic                 sign_r;
  logic                 sign_n_s;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   acc_n_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_n_s;
  logic [2*WIDTH-1:0]   out_r;
  logic [2*WIDTH-1:0]   out_n_s;
  logic                 out_sign_r;
  logic                 out_sign_n_s;
  logic                 busy_r;
  logic                 busy_n_s;
  logic                 done_r;
  logic                 done_n_s;

  // Partial product of the current digit and the running accumulation.
  // Working modulo 2^(2*WIDTH) is exact because the final product fits.
  logic [2*WIDTH-1:0]   digit_s;
  logic [2*WIDTH-1:0]   partial_s;
  logic [2*WIDTH-1:0]   acc_sum_s;

  assign digit_s   = {{(2*WIDTH-STEP){1'b0}}, b_r[STEP-1:0]};
  assign partial_s = a_sh_r * digit_s;
  assign acc_sum_s = acc_r + partial_s;

  assign out      = out_r;
  assign out_sign = out_sign_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Next-state and next-datapath logic; every register holds unless told otherwise.
  always_comb begin
    state_n_s    = state_r;
    a_sh_n_s     = a_sh_r;
    b_n_s        = b_r;
    sign_n_s     = sign_r;
    acc_n_s      = acc_r;
    cnt_n_s      = cnt_r;
    out_n_s      = out_r;
    out_sign_n_s = out_sign_r;
    busy_n_s     = busy_r;
    done_n_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // Capture operands now; later input changes cannot affect this op.
          a_sh_n_s  = {{WIDTH{1'b0}}, a};
          b_n_s     = b;
          sign_n_s  = sign_a ^ sign_b;
          acc_n_s   = {(2*WIDTH){1'b0}};
          cnt_n_s   = CNT_ZERO;
          busy_n_s  = 1'b1;
          state_n_s = ST_RUN;
        end else begin
          busy_n_s  = 1'b0;
        end
      end

      ST_RUN: begin
        // start is ignored here: a request while busy is simply dropped.
        a_sh_n_s = a_sh_r << STEP;
        b_n_s    = b_r >> STEP;
        if (cnt_r == CNT_LAST) begin
          // Last digit: publish the finished sum straight into the result.
          out_n_s      = acc_sum_s;
          out_sign_n_s = sign_r;
          acc_n_s      = acc_sum_s;
          cnt_n_s      = CNT_ZERO;
          busy_n_s     = 1'b0;
          done_n_s     = 1'b1;
          state_n_s    = ST_IDLE;
        end else begin
          acc_n_s      = acc_sum_s;
          cnt_n_s      = cnt_r + CNT_ONE;
          busy_n_s     = 1'b1;
        end
      end

      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = CNT_ZERO;
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // FSM state register; reset overrides any simultaneous start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Datapath and output registers; reset mid-operation aborts without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_r     <= {(2*WIDTH){1'b0}};
      b_r        <= {WIDTH{1'b0}};
      sign_r     <= 1'b0;
      acc_r      <= {(2*WIDTH){1'b0}};
      cnt_r      <= CNT_ZERO;
      out_r      <= {(2*WIDTH){1'b0}};
      out_sign_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      a_sh_r     <= a_sh_n_s;
      b_r        <= b_n_s;
      sign_r     <= sign_n_s;
      acc_r      <= acc_n_s;
      cnt_r      <= cnt_n_s;
      out_r      <= out_n_s;
      out_sign_r <= out_sign_n_s;
      busy_r     <= busy_n_s;
      done_r     <= done_n_s;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: drives four mul_iter instances (STEP = 1, 2, 3, 5, WIDTH = 30)
// from shared inputs and compares against plain a*b arithmetic.
module tb_mul_iter;

  localparam int W  = 30;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic          sign_a;
  logic [W-1:0]  b;
  logic          sign_b;

  logic [2*W-1:0] outv  [ND];
  logic           osv   [ND];
  logic           busyv [ND];
  logic           donev [ND];

  int steps [ND] = '{1, 2, 3, 5};

  int n_assert = 0;
  int n_fail   = 0;

  // Last result published by the STEP=1 instance; out must hold it during RUN.
  logic [2*W-1:0] last_out0;
  logic           last_sign0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
    mul_iter #(.WIDTH(W), .STEP(ST)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .sign_a   (sign_a),
      .b        (b),
      .sign_b   (sign_b),
      .out      (outv[g]),
      .out_sign (osv[g]),
      .busy     (busyv[g]),
      .done     (donev[g])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = {W{1'b0}};
      1:       v = {W{1'b1}};
      2:       v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // One operation with a single-cycle start; every instance is checked.
  task automatic run_op(input logic [W-1:0] ta, input logic tsa,
                        input logic [W-1:0] tbv, input logic tsb, input string tag);
    int dcnt [ND];
    int dk   [ND];
    logic [2*W-1:0] dout [ND];
    logic dsg [ND];
    int bcnt;
    logic [63:0] expp;
    logic exps;
    expp = 64'(ta) * 64'(tbv);
    exps = tsa ^ tsb;
    bcnt = 0;
    for (int g = 0; g < ND; g++) begin
      dcnt[g] = 0; dk[g] = -1; dout[g] = '0; dsg[g] = 1'b0;
    end
    @(negedge clk);
    a = ta; sign_a = tsa; b = tbv; sign_b = tsb; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        sign_a = 1'($urandom_range(0, 1)); sign_b = 1'($urandom_range(0, 1));
      end
      if (k == 10) begin
        check_val({tag, " hold0"}, 64'(outv[0]), 64'(last_out0));
        check_val({tag, " holds0"}, 64'(osv[0]), 64'(last_sign0));
      end
      if (busyv[0]) bcnt++;
      for (int g = 0; g < ND; g++) begin
        if (donev[g]) begin
          dcnt[g]++; dk[g] = k; dout[g] = outv[g]; dsg[g] = osv[g];
        end
      end
    end
    for (int g = 0; g < ND; g++) begin
      check_val($sformatf("%s s%0d lat", tag, steps[g]), 64'(dk[g]), 64'(W / steps[g]));
      check_val($sformatf("%s s%0d ndone", tag, steps[g]), 64'(dcnt[g]), 64'd1);
      check_val($sformatf("%s s%0d out", tag, steps[g]), 64'(dout[g]), expp);
      check_val($sformatf("%s s%0d sign", tag, steps[g]), 64'(dsg[g]), 64'(exps));
    end
    check_val({tag, " busycyc"}, 64'(bcnt), 64'(W));
    last_out0  = 60'(expp);
    last_sign0 = exps;
  endtask

  initial begin
    int nd;
    int nb;
    logic [63:0] p1;
    logic [63:0] p3;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; sign_a = 1'b0; sign_b = 1'b0;
    last_out0 = '0; last_sign0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check_val($sformatf("rst s%0d out", steps[g]), 64'(outv[g]), 64'd0);
      check_val($sformatf("rst s%0d sign", steps[g]), 64'(osv[g]), 64'd0);
      check_val($sformatf("rst s%0d busy", steps[g]), 64'(busyv[g]), 64'd0);
      check_val($sformatf("rst s%0d done", steps[g]), 64'(donev[g]), 64'd0);
    end

    // Directed vectors.
    run_op(30'd792348734, 1'b0, 30'd234234234, 1'b0, "t1");
    check_val("t1 const", 64'(last_out0), 64'd185595198769359756);
    run_op(30'h3FFFFFFF, 1'b1, 30'h3FFFFFFF, 1'b0, "t2");
    check_val("t2 const", 64'(last_out0), 64'h0FFFFFFF80000001);
    run_op(30'd0, 1'b1, 30'd5, 1'b0, "t3");
    run_op(30'd12345, 1'b1, 30'd0, 1'b1, "bzero");

    // start held three cycles with operands changing, then back-to-back start.
    p1 = 64'(30'd1000003) * 64'(30'd777777);
    p3 = 64'(30'd99991) * 64'(30'd31337);
    @(negedge clk);
    a = 30'd1000003; b = 30'd777777; sign_a = 1'b1; sign_b = 1'b0; start = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (donev[0]) nd++;
      if (k == 0) begin a = 30'd5; b = 30'd6; sign_a = 1'b0; end
      if (k == 1) begin a = 30'd7; b = 30'd8; sign_b = 1'b1; end
      if (k == 2) start = 1'b0;
    end
    check_val("t4 early done", 64'(nd), 64'd0);
    @(negedge clk);
    check_val("t4 done", 64'(donev[0]), 64'd1);
    check_val("t4 busy", 64'(busyv[0]), 64'd0);
    check_val("t4 out", 64'(outv[0]), p1);
    check_val("t4 sign", 64'(osv[0]), 64'd1);
    a = 30'd99991; b = 30'd31337; sign_a = 1'b0; sign_b = 1'b0; start = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        check_val("t4 pulse", 64'(donev[0]), 64'd0);
        check_val("t4 busy2", 64'(busyv[0]), 64'd1);
      end
      if (k == 15) check_val("t4 hold", 64'(outv[0]), p1);
      if (donev[0]) nd++;
    end
    check_val("t4 early done2", 64'(nd), 64'd0);
    @(negedge clk);
    check_val("t4 done2", 64'(donev[0]), 64'd1);
    check_val("t4 out2", 64'(outv[0]), p3);
    check_val("t4 sign2", 64'(osv[0]), 64'd0);
    repeat (35) @(negedge clk);
    last_out0 = 60'(p3); last_sign0 = 1'b0;

    // Reset twelve cycles into RUN aborts the operation.
    @(negedge clk);
    a = 30'd4242; b = 30'd9999; sign_a = 1'b1; sign_b = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("t5 busy", 64'(busyv[0]), 64'd0);
    check_val("t5 out", 64'(outv[0]), 64'd0);
    check_val("t5 sign", 64'(osv[0]), 64'd0);
    check_val("t5 done", 64'(donev[0]), 64'd0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (donev[0]) nd++;
    end
    check_val("t5 no done", 64'(nd), 64'd0);
    last_out0 = '0; last_sign0 = 1'b0;
    run_op(30'd4242, 1'b1, 30'd9999, 1'b0, "t5 after");

    // reset and start together: start is dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 30'd3; b = 30'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    nd = 0; nb = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (donev[0]) nd++;
      if (busyv[0]) nb++;
    end
    check_val("rst+start busy", 64'(nb), 64'd0);
    check_val("rst+start done", 64'(nd), 64'd0);
    last_out0 = '0; last_sign0 = 1'b0;

    // Random sweep across all four STEP values.
    for (int i = 0; i < 1000; i++) begin
      run_op(rnd_op(), 1'($urandom_range(0, 1)), rnd_op(), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
